// File: rtl/video_trig_pkg.sv
// Shared types and defaults for the video trigger/capture sequencer.
package video_trig_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

endpackage

// File: rtl/video_trig_match.sv
// Masked equality comparator with a registered match flag.
module video_trig_match #(
    parameter int DATA_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_value,
    input  logic [DATA_W-1:0] i_mask,
    output logic              o_match
);

    logic r_match;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_match <= 1'b0;
        end else begin
            r_match <= ((i_data ^ i_value) & i_mask) == '0;
        end
    end

    assign o_match = r_match;

endmodule

// File: rtl/video_trig_seq.sv
// Pre/post-trigger capture sequencer writing sampled video into a ring buffer.
module video_trig_seq
    import video_trig_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              ov5640_pclk,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] video,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [ADDR_W-1:0] pre_cnt,
    input  logic [ADDR_W-1:0] post_cnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);

    localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_video_q;
    logic [DATA_W-1:0] r_value_l;
    logic [DATA_W-1:0] r_mask_l;
    logic [ADDR_W-1:0] r_pre_l;
    logic [ADDR_W-1:0] r_post_l;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_trig_addr;
    logic              r_trig;
    logic              r_done;

    logic              w_arm_ok;
    logic              w_abort;
    logic              w_match;
    logic              w_wr_en;
    logic              w_pre_last;
    logic              w_post_last;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_post_clamp;
    logic [DATA_W-1:0] w_cmp_value;
    logic [DATA_W-1:0] w_cmp_mask;

    assign w_abort  = abort && (r_state != ST_IDLE);
    assign w_arm_ok = arm && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // ~pre_cnt is DEPTH-1-pre_cnt, the largest post count that still fits the buffer.
    assign w_sum        = {1'b0, pre_cnt} + {1'b0, post_cnt} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_post_clamp = (w_sum > DEPTH_V) ? ~pre_cnt : post_cnt;

    assign w_pre_last  = (r_cnt == r_pre_l - A_ONE);
    assign w_post_last = (r_cnt == r_post_l - A_ONE);

    // The comparator registers video and the next-cycle configuration, so its output
    // is the match of video_q against the latched configuration in the same cycle.
    assign w_cmp_value = w_arm_ok ? trig_value : r_value_l;
    assign w_cmp_mask  = w_arm_ok ? trig_mask  : r_mask_l;

    video_trig_match #(.DATA_W(DATA_W)) u_match (
        .i_clk   (ov5640_pclk),
        .i_rst   (rst_i),
        .i_data  (video),
        .i_value (w_cmp_value),
        .i_mask  (w_cmp_mask),
        .o_match (w_match)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_arm_ok) w_state_nxt = (pre_cnt == '0) ? ST_WAIT : ST_PRE;
            end
            ST_PRE: begin
                w_wr_en = 1'b1;
                if (w_pre_last) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_wr_en = 1'b1;
                if (w_match) w_state_nxt = (r_post_l == '0) ? ST_DONE : ST_POST;
            end
            ST_POST: begin
                w_wr_en = 1'b1;
                if (w_post_last) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge ov5640_pclk) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge ov5640_pclk) begin
        if (rst_i) begin
            r_video_q   <= '0;
            r_value_l   <= '0;
            r_mask_l    <= '0;
            r_pre_l     <= '0;
            r_post_l    <= '0;
            r_wr_addr   <= '0;
            r_cnt       <= '0;
            r_trig_addr <= '0;
            r_trig      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_video_q <= video;
            if (w_abort) begin
                r_trig <= 1'b0;
                r_done <= 1'b0;
            end else if (w_arm_ok) begin
                r_value_l <= trig_value;
                r_mask_l  <= trig_mask;
                r_pre_l   <= pre_cnt;
                r_post_l  <= w_post_clamp;
                r_wr_addr <= '0;
                r_cnt     <= '0;
                r_trig    <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                if (w_wr_en) r_wr_addr <= r_wr_addr + A_ONE;
                case (r_state)
                    ST_PRE:  r_cnt <= w_pre_last ? '0 : r_cnt + A_ONE;
                    ST_WAIT: begin
                        if (w_match) begin
                            r_trig_addr <= r_wr_addr;
                            r_trig      <= 1'b1;
                            r_cnt       <= '0;
                            if (r_post_l == '0) r_done <= 1'b1;
                        end
                    end
                    ST_POST: begin
                        r_cnt <= r_cnt + A_ONE;
                        if (w_post_last) r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en      = w_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_video_q;
    assign busy       = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign triggered  = r_trig;
    assign done       = r_done;
    assign trig_addr  = r_trig_addr;
    assign start_addr = r_trig_addr - r_pre_l;

endmodule

// File: tb/tb_video_trig_seq.sv
// Directed bench for video_trig_seq: buffer writes checked through an expected queue.
module tb_video_trig_seq;

    localparam int DW = 20;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] video;
    logic          arm;
    logic          abort;
    logic [DW-1:0] trig_value;
    logic [DW-1:0] trig_mask;
    logic [AW-1:0] pre_cnt;
    logic [AW-1:0] post_cnt;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW+DW-1:0] exp_q[$];

    video_trig_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .ov5640_pclk (clk),
        .rst_i       (rst_i),
        .video       (video),
        .arm         (arm),
        .abort       (abort),
        .trig_value  (trig_value),
        .trig_mask   (trig_mask),
        .pre_cnt     (pre_cnt),
        .post_cnt    (post_cnt),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .triggered   (triggered),
        .done        (done),
        .trig_addr   (trig_addr),
        .start_addr  (start_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every buffer write must match the oldest expected entry.
    always @(negedge clk) begin
        logic [AW+DW-1:0] item;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
            end else begin
                item = exp_q.pop_front();
                check("write", {wr_addr, wr_data}, item);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        video = video + 20'd1;
    endtask

    task automatic push_ramp(input int count, input logic [DW-1:0] k0);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < count; i++) begin
            a = AW'(i);
            d = k0 + DW'(i);
            exp_q.push_back({a, d});
        end
    endtask

    task automatic arm_cfg(input logic [DW-1:0] val, input logic [DW-1:0] msk,
                           input logic [AW-1:0] pre, input logic [AW-1:0] post,
                           input logic [DW-1:0] k0);
        trig_value = val;
        trig_mask  = msk;
        pre_cnt    = pre;
        post_cnt   = post;
        video      = k0;
        arm        = 1'b1;
        step();
        arm        = 1'b0;
    endtask

    task automatic run_until_done(input int max, output int n);
        n = 0;
        while (done !== 1'b1 && n < max) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_i = 1'b1; video = '0; arm = 1'b0; abort = 1'b0;
        trig_value = '0; trig_mask = '0; pre_cnt = '0; post_cnt = '0;
        repeat (3) step();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_start_addr", start_addr, 0);
        rst_i = 1'b0;
        step();

        // Basic capture: 4 pre, match on the 12th WAIT sample, 3 post.
        push_ramp(19, 20'h00AAD);
        arm_cfg(20'h00ABC, 20'hFFFFF, 4'd4, 4'd3, 20'h00AAD);
        check("basic_busy", busy, 1);
        run_until_done(40, n);
        check("basic_cycles", n, 19);
        check("basic_done", done, 1);
        check("basic_triggered", triggered, 1);
        check("basic_trig_addr", trig_addr, 15);
        check("basic_start_addr", start_addr, 11);
        check("basic_busy_end", busy, 0);

        // Zero counts with an all-zero mask: one write, done the next cycle.
        push_ramp(1, 20'h12345);
        arm_cfg(20'h00000, 20'h00000, 4'd0, 4'd0, 20'h12345);
        run_until_done(10, n);
        check("zero_cycles", n, 1);
        check("zero_trig_addr", trig_addr, 0);
        check("zero_start_addr", start_addr, 0);
        check("zero_triggered", triggered, 1);

        // Long wait wraps the ring: match on write 22, one post sample.
        push_ramp(24, 20'h00100);
        arm_cfg(20'h00116, 20'hFFFFF, 4'd2, 4'd1, 20'h00100);
        run_until_done(60, n);
        check("wrap_cycles", n, 24);
        check("wrap_trig_addr", trig_addr, 6);
        check("wrap_start_addr", start_addr, 4);
        check("wrap_wr_addr", wr_addr, 8);

        // Post count clamped to DEPTH-1-pre = 5.
        push_ramp(16, 20'h20000);
        arm_cfg(20'h00000, 20'h00000, 4'd10, 4'd10, 20'h20000);
        run_until_done(40, n);
        check("clamp_cycles", n, 16);
        check("clamp_trig_addr", trig_addr, 10);
        check("clamp_start_addr", start_addr, 0);

        // Abort during POST, then arm+abort together in IDLE.
        push_ramp(4, 20'h30000);
        arm_cfg(20'h00000, 20'h00000, 4'd1, 4'd8, 20'h30000);
        repeat (3) step();
        check("post_triggered", triggered, 1);
        check("post_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_wr_en", wr_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_triggered", triggered, 0);
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        check("armabort_busy", busy, 0);
        check("armabort_wr_en", wr_en, 0);
        repeat (3) step();

        // Arm while busy is ignored; reset in WAIT stops writes at once.
        push_ramp(5, 20'h00200);
        arm_cfg(20'hFFFFF, 20'hFFFFF, 4'd2, 4'd2, 20'h00200);
        repeat (2) step();
        trig_value = '0; trig_mask = '0; pre_cnt = '0; post_cnt = '0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("ignarm_triggered", triggered, 0);
        check("ignarm_wr_addr", wr_addr, 3);
        check("ignarm_busy", busy, 1);
        step();
        rst_i = 1'b1;
        step();
        check("midrst_wr_en", wr_en, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_triggered", triggered, 0);
        check("midrst_done", done, 0);
        check("midrst_trig_addr", trig_addr, 0);
        check("midrst_start_addr", start_addr, 0);
        step();
        rst_i = 1'b0;
        repeat (3) step();

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
